// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture for the serial deterministic stochastic multiplier.
// Runs dsc_mul for exactly one full stream period per accepted operand pair.
module dsc_mul_seq #(
    parameter int SNG_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SNG_WIDTH-1:0]     a_in,
    input  logic [SNG_WIDTH-1:0]     b_in,
    output logic [SNG_WIDTH-1:0]     mul_a,
    output logic [SNG_WIDTH-1:0]     mul_b,
    output logic                     mul_rst,
    output logic                     mul_en,
    input  logic [2*SNG_WIDTH-1:0]   mul_z,
    input  logic                     mul_ov,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*SNG_WIDTH-1:0]   z_out,
    output logic                     ov_err,
    output logic                     busy,
    output logic [2:0]               state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is only high in IDLE (and never during rst); out_valid holds z_out/ov_err
    // stable until out_ready is seen.

    localparam int ZW = 2 * SNG_WIDTH;
    localparam int CW = ZW + 1;

    localparam logic [CW-1:0] CNT_LAST = {1'b0, {ZW{1'b1}}};
    localparam logic [CW-1:0] CNT_ONE  = {{ZW{1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          ov_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            z_out     <= '0;
            ov_err    <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            ov_seen   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_a <= a_in;
                        mul_b <= b_in;
                        cnt   <= '0;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    ov_seen <= 1'b0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (mul_ov) begin
                        ov_seen <= 1'b1;
                    end
                    // Terminal compare precedes the increment, so the counter never wraps.
                    if (cnt == CNT_LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    z_out  <= mul_z;
                    ov_err <= ~ov_seen;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    // Capture happened on entry; the product is presented one edge later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE) & ~rst;
    assign mul_rst   = rst | (state == S_CLEAR);
    assign mul_en    = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural dsc_mul stub and an expected-result queue.
module tb_dsc_mul_seq;

    localparam int W  = 6;
    localparam int ZW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          in_ready;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_rst;
    logic          mul_en;
    logic [ZW-1:0] mul_z;
    logic          mul_ov;
    logic          out_valid;
    logic [ZW-1:0] z_out;
    logic          ov_err;
    logic          busy;
    logic [2:0]    state_dbg;

    logic          ov_kill = 1'b0;
    logic [ZW-1:0] stub_cnt;
    logic [ZW-1:0] stub_z;

    logic [ZW-1:0] exp_q[$];
    logic          exp_ov_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            en_cnt = 0;

    dsc_mul_seq #(.SNG_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mul_a(mul_a), .mul_b(mul_b),
        .mul_rst(mul_rst), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov),
        .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out),
        .ov_err(ov_err), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset-free counters
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mul_en === 1'b1) en_cnt <= en_cnt + 1;

    // Stub multiplier: one stream period visits every (lo,hi) pair once, counting a*b hits.
    always @(posedge clk) begin
        if (mul_rst) begin
            stub_cnt <= '0;
            stub_z   <= '0;
        end else if (mul_en) begin
            stub_cnt <= stub_cnt + 12'd1;
            if ((stub_cnt[W-1:0] < mul_a) && (stub_cnt[ZW-1:W] < mul_b))
                stub_z <= stub_z + 12'd1;
        end
    end
    assign mul_z  = stub_z;
    assign mul_ov = mul_en & (stub_cnt == 12'hfff) & ~ov_kill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver: one full operation, optional consumer stall and busy-time poke
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                          input logic exp_ov, input logic poke);
        int acc_cyc;
        int en_base;
        int n;
        logic [ZW-1:0] ez;
        logic          eo;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        acc_cyc = cyc;
        en_base = en_cnt;
        exp_q.push_back(ZW'(a) * ZW'(b));
        exp_ov_q.push_back(exp_ov);
        in_valid = 1'b0;
        a_in = ~a;
        b_in = ~b;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 5000) begin
            if (poke && n == 100) begin
                in_valid = 1'b1;
                a_in = 6'd1;
                b_in = 6'd1;
            end
            @(negedge clk);
            n++;
            if (poke && n == 102) begin
                check("in_ready_busy", 32'(in_ready), 32'd0);
                check("mul_a_held", 32'(mul_a), 32'(a));
            end
        end
        if (n >= 5000) begin
            check("timeout_out_valid", 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            return;
        end
        check("latency", 32'(cyc - acc_cyc), 32'd4099);
        check("mul_en_cycles", 32'(en_cnt - en_base), 32'd4096);
        check("mul_b_held", 32'(mul_b), 32'(b));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            ez = exp_q.pop_front();
            eo = exp_ov_q.pop_front();
            check("z_out", 32'(z_out), 32'(ez));
            check("ov_err", 32'(ov_err), 32'(eo));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_z_out", 32'(z_out), 32'(ez));
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        // reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_ready_in_rst", 32'(in_ready), 32'd0);
            check("mul_rst_in_rst", 32'(mul_rst), 32'd1);
        end
        check("reset_state", 32'(state_dbg), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_z_out", 32'(z_out), 32'd0);
        check("rel_mul_en", 32'(mul_en), 32'd0);
        check("rel_mul_rst", 32'(mul_rst), 32'd0);

        run_op(6'd5, 6'd9, 0, 1'b0, 1'b0);
        run_op(6'd63, 6'd63, 0, 1'b0, 1'b0);
        run_op(6'd0, 6'd37, 0, 1'b0, 1'b0);
        run_op(6'd12, 6'd20, 50, 1'b0, 1'b1);

        // abort mid-RUN with reset
        @(negedge clk);
        a_in = 6'd9;
        b_in = 6'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (mul_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_run_seen", 32'(mul_en), 32'd1);
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_mul_rst_now", 32'(mul_rst), 32'd1);
        check("abort_in_ready_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mul_en", 32'(mul_en), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_mul_rst", 32'(mul_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rel_mul_rst", 32'(mul_rst), 32'd0);
        check("abort_rel_out_valid", 32'(out_valid), 32'd0);
        run_op(6'd3, 6'd3, 0, 1'b0, 1'b0);

        // multiplier never reports its period wrap
        ov_kill = 1'b1;
        run_op(6'd7, 6'd7, 0, 1'b1, 1'b0);
        ov_kill = 1'b0;

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
